// File: rtl/lzc_stim_src_if.sv
`default_nettype none
// ============================================================================
//  Module   : lzc_stim_src_if
//  Purpose  : Command/report bus and LZC-facing stream bus for lzc_stim_src.
//             The master modport is the stimulus source; the slave modport
//             is the command issuer and LZC side.
//  Revision : 1.0  initial release
// ============================================================================
interface lzc_stim_src_if #(
  parameter int WIDTH = 8,
  parameter int WORD  = 4
);
  localparam int CW = $clog2(WIDTH*WORD) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_zeros;
  logic          cmd_mode;
  logic [WIDTH-1:0] data;
  logic          dvalid;
  logic          mode;
  logic [CW-1:0] zeros;
  logic          ovalid;
  logic          done;
  logic          match;
  logic          timeout;
  logic [CW-1:0] result;

  modport master (
    input  cmd_valid, cmd_zeros, cmd_mode, zeros, ovalid,
    output cmd_ready, data, dvalid, mode, done, match, timeout, result
  );

  modport slave (
    output cmd_valid, cmd_zeros, cmd_mode, zeros, ovalid,
    input  cmd_ready, data, dvalid, mode, done, match, timeout, result
  );
endinterface
`default_nettype wire

// File: rtl/lzc_stim_src.sv
`default_nettype none
// ============================================================================
//  Module   : lzc_stim_src
//  Purpose  : Stimulus source for the multi-word leading-zero counter. Turns
//             a (zero count, mode) command into WORD words of WIDTH bits,
//             MSB-first, with exactly that many leading zeros, then checks
//             the LZC response against the expected count.
//  Options  : LZC_STIM_LFSR_EN - fill bits after the leading one come from an
//             8-bit Fibonacci LFSR instead of constant ones.
//  Revision : 1.0  initial release
// ============================================================================
module lzc_stim_src #(
  parameter int WIDTH   = 8,
  parameter int WORD    = 4,
  parameter int TIMEOUT = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  lzc_stim_src_if.master      bus
);

  localparam int CW      = $clog2(WIDTH*WORD) + 1;
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int c_TOTAL = WIDTH * WORD;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SEND   = 2'd1;
  localparam logic [1:0] c_WAIT   = 2'd2;
  localparam logic [1:0] c_REPORT = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_z;
  logic             r_mode;
  logic [CW-1:0]    r_last;
  logic [CW-1:0]    r_word;
  logic [TW-1:0]    r_wait;
  logic [WIDTH-1:0] r_data;
  logic             r_dvalid;
  logic             r_done;
  logic             r_match;
  logic             r_timeout;
  logic [CW-1:0]    r_result;
  logic             r_captured;

  logic [CW-1:0]    w_z_in;
  logic [CW-1:0]    w_last_in;
  logic [CW-1:0]    w_gen_z;
  logic [CW-1:0]    w_gen_k;
  logic [WIDTH-1:0] w_fill;
  logic [WIDTH-1:0] w_next_word;
  logic [TW-1:0]    w_wait_inc;

  // Bit b of word k carries global index k*WIDTH + (WIDTH-1-b): zero before
  // the target, one at the target, fill after it.
  function automatic logic [WIDTH-1:0] gen_word(input logic [CW-1:0] z,
                                                input logic [CW-1:0] k,
                                                input logic [WIDTH-1:0] fill);
    logic [WIDTH-1:0] w;
    int idx;
    w = '0;
    for (int b = 0; b < WIDTH; b++) begin
      idx = int'(k) * WIDTH + (WIDTH - 1 - b);
      if (idx < int'(z))
        w[b] = 1'b0;
      else if (idx == int'(z))
        w[b] = 1'b1;
      else
        w[b] = fill[b];
    end
    return w;
  endfunction

  assign w_z_in    = (bus.cmd_zeros > CW'(c_TOTAL)) ? CW'(c_TOTAL) : bus.cmd_zeros;
  // Turbo stops at the word holding the leading one; an all-zero stream has
  // no leading one, so it always sends every word.
  assign w_last_in = (!bus.cmd_mode || (w_z_in == CW'(c_TOTAL))) ? CW'(WORD - 1)
                                                                 : (w_z_in / CW'(WIDTH));

  // Word 0 is built from the live command; later words from the latched one.
  assign w_gen_z     = (r_state == c_IDLE) ? w_z_in : r_z;
  assign w_gen_k     = (r_state == c_IDLE) ? '0 : (r_word + CW'(1));
  assign w_next_word = gen_word(w_gen_z, w_gen_k, w_fill);
  assign w_wait_inc  = r_wait + TW'(1);

`ifdef LZC_STIM_LFSR_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_step;

  assign w_lfsr_step = ((r_state == c_IDLE) && bus.cmd_valid) ||
                       ((r_state == c_SEND) && (r_word != r_last));

  // Fill pattern generator, stepped once for every word loaded onto data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lfsr <= 8'hA5;
    else if (w_lfsr_step)
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  for (genvar gb = 0; gb < WIDTH; gb++) begin : g_fill
    assign w_fill[gb] = r_lfsr[gb % 8];
  end
`else
  assign w_fill = '1;
`endif

  // Command sequencer: accept, stream words, collect response, report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_z        <= '0;
      r_mode     <= 1'b0;
      r_last     <= '0;
      r_word     <= '0;
      r_wait     <= '0;
      r_data     <= '0;
      r_dvalid   <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
      r_timeout  <= 1'b0;
      r_result   <= '0;
      r_captured <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.cmd_valid) begin
            r_z        <= w_z_in;
            r_mode     <= bus.cmd_mode;
            r_last     <= w_last_in;
            r_word     <= '0;
            r_wait     <= '0;
            r_data     <= w_next_word;
            r_dvalid   <= 1'b1;
            r_match    <= 1'b0;
            r_timeout  <= 1'b0;
            r_result   <= '0;
            r_captured <= 1'b0;
            r_state    <= c_SEND;
          end
        end
        c_SEND: begin
          // An early response is kept; the stream still runs to its end.
          if (bus.ovalid && !r_captured) begin
            r_result   <= bus.zeros;
            r_match    <= (bus.zeros == r_z);
            r_captured <= 1'b1;
          end
          if (r_word == r_last) begin
            r_dvalid <= 1'b0;
            r_data   <= '0;
            r_wait   <= '0;
            if (r_captured || bus.ovalid) begin
              r_done  <= 1'b1;
              r_state <= c_REPORT;
            end else begin
              r_state <= c_WAIT;
            end
          end else begin
            r_word <= r_word + CW'(1);
            r_data <= w_next_word;
          end
        end
        c_WAIT: begin
          if (bus.ovalid) begin
            r_result <= bus.zeros;
            r_match  <= (bus.zeros == r_z);
            r_done   <= 1'b1;
            r_state  <= c_REPORT;
          end else if (w_wait_inc == TW'(TIMEOUT)) begin
            r_timeout <= 1'b1;
            r_result  <= '0;
            r_match   <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= c_REPORT;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        c_REPORT: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == c_IDLE);
  assign bus.data      = r_data;
  assign bus.dvalid    = r_dvalid;
  assign bus.mode      = r_mode;
  assign bus.done      = r_done;
  assign bus.match     = r_match;
  assign bus.timeout   = r_timeout;
  assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_lzc_stim_src.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lzc_stim_src
//  Purpose  : Self-checking bench for lzc_stim_src; plays the command issuer
//             and the LZC response side, predicting each stream from the
//             leading-zero rule on a flat bit vector.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lzc_stim_src;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lzc_stim_src_if #(.WIDTH(W), .WORD(N)) bus ();

  lzc_stim_src #(.WIDTH(W), .WORD(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

`ifdef LZC_STIM_LFSR_EN
  logic [7:0] m_lfsr;
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = no response, 1 = response dly cycles after the stream ends,
  //       2 = response while word dly is on the bus.
  task automatic run_cmd(input int z_raw, input bit m, input int kind,
                         input int dly_in, input int val, input bit hold);
    int z, nw, k, n, exp_n, dly;
    logic [31:0] stream;
    logic [7:0]  words [0:3];
    logic [7:0]  lv [0:4];
    bit fb;
    z  = (z_raw > W*N) ? W*N : z_raw;
    nw = (m && z < W*N) ? z / W + 1 : N;
    dly = (kind == 2 && dly_in >= nw) ? nw - 1 : dly_in;
`ifdef LZC_STIM_LFSR_EN
    lv[0] = m_lfsr;
    for (int j = 0; j < 4; j++) lv[j+1] = lfsr_step(lv[j]);
    m_lfsr = lv[nw];
`else
    for (int j = 0; j < 5; j++) lv[j] = 8'hFF;
`endif
    for (int i = 0; i < W*N; i++) begin
      fb = lv[i / W][W - 1 - (i % W)];
      stream[W*N-1-i] = (i < z) ? 1'b0 : ((i == z) ? 1'b1 : fb);
    end
    for (int j = 0; j < N; j++) words[j] = stream[W*N-1-W*j -: W];

    @(negedge clk);
    chk("idle_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_zeros = 6'(z_raw);
    bus.cmd_mode  = m;
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;

    k = 0;
    while (bus.dvalid === 1'b1 && k < 8) begin
      if (k < N) chk("data", 32'(bus.data), 32'(words[k]));
      chk("mode", 32'(bus.mode), 32'(m));
      chk("busy_ready", 32'(bus.cmd_ready), 0);
      bus.ovalid = (kind == 2 && k == dly);
      bus.zeros  = 6'(val);
      k++;
      @(negedge clk);
    end
    bus.ovalid = 1'b0;
    chk("nwords", 32'(k), 32'(nw));

    n = 0;
    while (n < 40 && bus.done !== 1'b1) begin
      chk("wait_ready", 32'(bus.cmd_ready), 0);
      bus.ovalid = (kind == 1 && n == dly);
      bus.zeros  = 6'(val);
      @(negedge clk);
      n++;
    end
    bus.ovalid = 1'b0;
    exp_n = (kind == 2) ? 0 : ((kind == 1) ? dly + 1 : TO);
    chk("done_latency", 32'(n), 32'(exp_n));
    chk("done_ready", 32'(bus.cmd_ready), 0);
    chk("timeout", 32'(bus.timeout), 32'(kind == 0));
    chk("match", 32'(bus.match), 32'(kind != 0 && val == z));
    chk("result", 32'(bus.result), (kind == 0) ? 0 : 32'(val));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("done_pulse", 32'(bus.done), 0);
    chk("ready_after", 32'(bus.cmd_ready), 1);
    chk("result_hold", 32'(bus.result), (kind == 0) ? 0 : 32'(val));
  endtask

  initial begin
    int z, kind, val, nwr;
    bit m;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_zeros = '0;
    bus.cmd_mode  = 1'b0;
    bus.zeros     = '0;
    bus.ovalid    = 1'b0;
`ifdef LZC_STIM_LFSR_EN
    m_lfsr = 8'hA5;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready",   32'(bus.cmd_ready), 1);
    chk("rst_dvalid",  32'(bus.dvalid), 0);
    chk("rst_data",    32'(bus.data), 0);
    chk("rst_mode",    32'(bus.mode), 0);
    chk("rst_done",    32'(bus.done), 0);
    chk("rst_match",   32'(bus.match), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_result",  32'(bus.result), 0);
    rst_n = 1'b1;

    run_cmd(10, 1'b0, 1, 2, 10, 1'b0);
    run_cmd(10, 1'b1, 1, 2, 10, 1'b0);
    run_cmd(40, 1'b0, 1, 1, 31, 1'b0);
    run_cmd(40, 1'b1, 1, 1, 31, 1'b0);
    run_cmd(32, 1'b1, 1, 0, 32, 1'b0);
    run_cmd(0,  1'b0, 0, 0, 0,  1'b0);
    run_cmd(16, 1'b1, 2, 1, 16, 1'b1);
    run_cmd(8,  1'b0, 1, 3, 5,  1'b1);

    // Reset while word 2 of a normal stream is on the bus.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_zeros = 6'd20;
    bus.cmd_mode  = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_dvalid", 32'(bus.dvalid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_dvalid", 32'(bus.dvalid), 0);
    chk("mid_rst_ready",  32'(bus.cmd_ready), 1);
    chk("mid_rst_data",   32'(bus.data), 0);
`ifdef LZC_STIM_LFSR_EN
    m_lfsr = 8'hA5;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(8, 1'b0, 1, 2, 8, 1'b0);

    for (int t = 0; t < 40; t++) begin
      z    = $urandom_range(0, 63);
      m    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      nwr  = (m && z < W*N) ? z / W + 1 : N;
      val  = ($urandom_range(0, 1) == 1) ? ((z > W*N) ? W*N : z) : $urandom_range(0, 32);
      run_cmd(z, m, kind,
              (kind == 2) ? $urandom_range(0, nwr - 1) : $urandom_range(0, 10),
              val, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
